// File: rtl/pool_sched.sv
// Frame sequencer for the shared 2x2/stride-2 maxpool engine: streams each channel in raster
// order, inserts post-trigger gaps, clears the engine between channels and packs pooled results.
module pool_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int NUM_CH     = 4,
    parameter int PIX_GAP    = 5,
    parameter int CLR_CYC    = 2,
    parameter int DRAIN_TO   = 16,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  fm_rd_en,
    output logic [ADDR_W-1:0]     fm_rd_addr,
    input  logic [DATA_WIDTH-1:0] fm_rd_data,
    output logic                  pool_rst,
    output logic [DATA_WIDTH-1:0] pool_din,
    output logic                  pool_valid,
    input  logic [DATA_WIDTH-1:0] pool_dout_in,
    input  logic                  pool_vout_in,
    output logic                  out_wr_en,
    output logic [ADDR_W-1:0]     out_wr_addr,
    output logic [DATA_WIDTH-1:0] out_wr_data
);
    localparam int NPOOL = (IMG_WIDTH / 2) * (IMG_HEIGHT / 2);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int K_W   = $clog2(NPOOL + 1);
    localparam int MAXC  = (DRAIN_TO > PIX_GAP) ? ((DRAIN_TO > CLR_CYC) ? DRAIN_TO : CLR_CYC)
                                                : ((PIX_GAP > CLR_CYC) ? PIX_GAP : CLR_CYC);
    localparam int CNT_W = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_FEED, S_HOLD, S_DRAIN, S_NEXT, S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [CH_W-1:0]    ch;
    logic [K_W-1:0]     k;
    logic [ADDR_W-1:0]  ch_base, row_base, out_base;
    logic               last_pix, trig_pix, k_full, drain_to;

    assign last_pix = (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));
    assign trig_pix = row[0] & col[0];
    assign k_full   = (k == K_W'(NPOOL));

    // Running base registers replace the ch*W*H, row*W and ch*NPOOL products.
    assign fm_rd_addr = fm_rd_en ? (ch_base + row_base + ADDR_W'(col)) : '0;
    assign pool_din   = pool_valid ? fm_rd_data : '0;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        pool_rst  = 1'b0;
        fm_rd_en  = 1'b0;
        drain_to  = 1'b0;
        case (state)
            S_IDLE: begin
                pool_rst = 1'b1;
                if (start) state_nxt = S_CLR;
            end
            S_CLR: begin
                pool_rst = 1'b1;
                busy     = 1'b1;
                if (cnt == CNT_W'(CLR_CYC - 1)) state_nxt = S_FEED;
            end
            S_FEED: begin
                busy     = 1'b1;
                fm_rd_en = 1'b1;
                if (last_pix)      state_nxt = S_DRAIN;
                else if (trig_pix) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                busy = 1'b1;
                if (cnt == CNT_W'(PIX_GAP - 1)) state_nxt = S_FEED;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (k_full) begin
                    state_nxt = S_NEXT;
                end else if (cnt == CNT_W'(DRAIN_TO - 1)) begin
                    drain_to  = 1'b1;
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                busy      = 1'b1;
                state_nxt = (ch == CH_W'(NUM_CH - 1)) ? S_DONE : S_CLR;
            end
            S_DONE: begin
                pool_rst  = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            col        <= '0;
            row        <= '0;
            ch         <= '0;
            ch_base    <= '0;
            row_base   <= '0;
            out_base   <= '0;
            pool_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pool_valid <= fm_rd_en;
            cnt        <= (state_nxt != state) ? '0 : cnt + 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    col      <= '0;
                    row      <= '0;
                    ch       <= '0;
                    ch_base  <= '0;
                    row_base <= '0;
                    out_base <= '0;
                end
                S_FEED: if (col == COL_W'(IMG_WIDTH - 1)) begin
                    col      <= '0;
                    row      <= row + 1'b1;
                    row_base <= row_base + ADDR_W'(IMG_WIDTH);
                end else begin
                    col <= col + 1'b1;
                end
                S_NEXT: begin
                    col      <= '0;
                    row      <= '0;
                    row_base <= '0;
                    if (ch != CH_W'(NUM_CH - 1)) begin
                        ch       <= ch + 1'b1;
                        ch_base  <= ch_base + ADDR_W'(IMG_WIDTH * IMG_HEIGHT);
                        out_base <= out_base + ADDR_W'(NPOOL);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
            k           <= '0;
            err         <= 1'b0;
        end else begin
            out_wr_en <= 1'b0;
            if (state == S_IDLE) begin
                if (start) err <= 1'b0;
            end else begin
                if (pool_vout_in) begin
                    if (!k_full) begin
                        out_wr_en   <= 1'b1;
                        out_wr_data <= pool_dout_in;
                        out_wr_addr <= out_base + ADDR_W'(k);
                        k           <= k + 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                end
                if (drain_to) err <= 1'b1;
                if (state == S_CLR) k <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pool_sched.sv
// Bench for pool_sched: behavioural feature memory and maxpool engine, scoreboard of expected writes.
module tb_pool_sched;
    localparam int DW = 16, W = 8, H = 8, NCH = 4, GAP = 5, CLRC = 2, DTO = 16, AW = 16;
    localparam int NP = (W / 2) * (H / 2);
    // Engine latency makes a normal drain last 3 cycles.
    localparam int DRAIN_NOM = 3;
    localparam int BUSY_NOM  = NCH * (CLRC + W * H + GAP * (NP - 1) + DRAIN_NOM + 1);

    logic          clk = 1'b0;
    logic          reset, start;
    logic          busy, done, err, fm_rd_en, pool_rst, pool_valid, out_wr_en;
    logic [AW-1:0] fm_rd_addr, out_wr_addr;
    logic [DW-1:0] fm_rd_data, pool_din, out_wr_data;
    logic [DW-1:0] pool_dout_in = '0;
    logic          pool_vout_in = 1'b0;

    pool_sched #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .NUM_CH(NCH), .PIX_GAP(GAP),
                 .CLR_CYC(CLRC), .DRAIN_TO(DTO), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
        .pool_rst(pool_rst), .pool_din(pool_din), .pool_valid(pool_valid),
        .pool_dout_in(pool_dout_in), .pool_vout_in(pool_vout_in),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];

    function automatic int pix_val(int a);
        return (a / (W * H)) * 100 + a % (W * H);
    endfunction

    function automatic int pooled(int c, int j);
        int m, v, r0, c0;
        r0 = 2 * (j / (W / 2));
        c0 = 2 * (j % (W / 2));
        m = -1;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                v = pix_val(c * W * H + (r0 + dr) * W + c0 + dc);
                if (v > m) m = v;
            end
        return m;
    endfunction

    always @(posedge clk)
        fm_rd_data <= fm_rd_en ? DW'(pix_val(int'(fm_rd_addr))) : DW'($urandom);

    // Engine model: emits the window max one cycle after each odd/odd pixel.
    logic signed [DW-1:0] ebuf [0:W*H-1];
    logic signed [DW-1:0] em;
    int  eidx = 0, emit_n = 0;
    int  drop_at = -1, dup_at = -1;
    bit  dup_pend = 1'b0;
    always @(posedge clk) begin
        pool_vout_in <= dup_pend;
        dup_pend = 1'b0;
        if (start && !busy) emit_n = 0;
        if (pool_rst) begin
            eidx = 0;
        end else if (pool_valid && eidx < W * H) begin
            ebuf[eidx] = pool_din;
            if ((eidx / W) % 2 == 1 && (eidx % W) % 2 == 1) begin
                em = ebuf[eidx];
                if (ebuf[eidx-1] > em) em = ebuf[eidx-1];
                if (ebuf[eidx-W] > em) em = ebuf[eidx-W];
                if (ebuf[eidx-W-1] > em) em = ebuf[eidx-W-1];
                if (emit_n != drop_at) begin
                    pool_vout_in <= 1'b1;
                    pool_dout_in <= em;
                end
                if (emit_n == dup_at) dup_pend = 1'b1;
                emit_n++;
            end
            eidx++;
        end
    end

    int r_busy, r_rd, r_addr_bad, r_gap_bad, r_rst_runs, r_rst_bad;
    bit r_fin, r_abort, r_err_start, r_err_done;

    task automatic push_frame(input int drop);
        wr_t e;
        int  k;
        for (int c = 0; c < NCH; c++) begin
            k = 0;
            for (int j = 0; j < NP; j++) begin
                if (c * NP + j == drop) continue;
                e.addr = c * NP + k;
                e.data = pooled(c, j);
                exp_q.push_back(e);
                k++;
            end
        end
    endtask

    task automatic run_frame(input bit hold_start, input int abort_addr);
        wr_t e;
        bit  pending;
        int  idle, run, p;
        r_busy = 0; r_rd = 0; r_addr_bad = 0; r_gap_bad = 0; r_rst_runs = 0; r_rst_bad = 0;
        r_fin = 0; r_abort = 0; r_err_done = 0;
        pending = 0; idle = 0; run = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); if (!hold_start) start = 1'b0;
        r_err_start = err;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (out_wr_en) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL wr_unexpected: got addr=%0d data=%0d, expected no write",
                             out_wr_addr, out_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_wr_addr !== AW'(e.addr) || out_wr_data !== DW'(e.data)) begin
                        fails++;
                        $display("FAIL wr_data: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                                 out_wr_addr, out_wr_data, e.addr, e.data);
                    end
                end
            end
            if (fm_rd_en) begin
                if (pending && idle != GAP) r_gap_bad++;
                if (fm_rd_addr !== AW'(r_rd)) r_addr_bad++;
                p = r_rd % (W * H);
                pending = ((p / W) % 2 == 1) && ((p % W) % 2 == 1) && (p != W * H - 1);
                idle = 0;
                r_rd++;
                if (r_rd - 1 == abort_addr) begin
                    r_abort = 1;
                    return;
                end
            end else if (pending) begin
                idle++;
            end
            if (pool_rst && busy) run++;
            else begin
                if (run == CLRC) r_rst_runs++;
                else if (run != 0) r_rst_bad++;
                run = 0;
            end
            if (busy) r_busy++;
            if (done) begin
                r_fin = 1;
                r_err_done = err;
                break;
            end
            @(negedge clk);
        end
        if (!r_fin) begin
            tests++; fails++;
            $display("FAIL frame_timeout: got no done within budget, expected done");
        end
    endtask

    task automatic check_reset_vals(input string tag);
        tests++;
        if ({busy, done, err, fm_rd_en, pool_valid, out_wr_en, pool_rst} !== 7'b0000001) begin
            fails++;
            $display("FAIL %s_ctrl: got %b, expected 0000001", tag,
                     {busy, done, err, fm_rd_en, pool_valid, out_wr_en, pool_rst});
        end
        tests++;
        if (fm_rd_addr !== '0 || out_wr_addr !== '0 || out_wr_data !== '0 || pool_din !== '0) begin
            fails++;
            $display("FAIL %s_data: got rd=%0d wa=%0d wd=%0d din=%0d, expected all 0", tag,
                     fm_rd_addr, out_wr_addr, out_wr_data, pool_din);
        end
    endtask

    task automatic check_frame(input string tag, input int busy_exp, input bit err_exp);
        tests++;
        if (r_busy != busy_exp) begin
            fails++;
            $display("FAIL %s_busy_cycles: got %0d, expected %0d", tag, r_busy, busy_exp);
        end
        tests++;
        if (r_rd != NCH * W * H || r_addr_bad != 0) begin
            fails++;
            $display("FAIL %s_reads: got %0d reads %0d bad addr, expected %0d reads 0 bad", tag,
                     r_rd, r_addr_bad, NCH * W * H);
        end
        tests++;
        if (r_err_done !== err_exp || r_err_start !== 1'b0) begin
            fails++;
            $display("FAIL %s_err: got start=%0b done=%0b, expected start=0 done=%0b", tag,
                     r_err_start, r_err_done, err_exp);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_missing_writes: got %0d left, expected 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        #1 check_reset_vals("reset");
        repeat (3) @(negedge clk);
        check_reset_vals("reset_held");
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_frame();
        push_frame(-1);
        run_frame(1'b0, -1);
        check_frame("frame", BUSY_NOM, 1'b0);
        tests++;
        if (r_gap_bad != 0) begin
            fails++;
            $display("FAIL gap: got %0d bad gaps, expected 0", r_gap_bad);
        end
        tests++;
        if (r_rst_runs != NCH || r_rst_bad != 0) begin
            fails++;
            $display("FAIL pool_rst_pulses: got %0d ok %0d bad, expected %0d ok 0 bad",
                     r_rst_runs, r_rst_bad, NCH);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: got done=%0b busy=%0b, expected 0 0", done, busy);
        end
    endtask

    task automatic test_drop();
        drop_at = NP + 5;
        push_frame(drop_at);
        run_frame(1'b0, -1);
        drop_at = -1;
        check_frame("drop", BUSY_NOM + DTO - DRAIN_NOM, 1'b1);
        repeat (3) @(negedge clk);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: got %0b, expected 1", err);
        end
    endtask

    task automatic test_excess();
        dup_at = 2 * NP - 1;
        push_frame(-1);
        run_frame(1'b0, -1);
        dup_at = -1;
        check_frame("excess", BUSY_NOM, 1'b1);
    endtask

    task automatic test_reset_midframe();
        push_frame(-1);
        run_frame(1'b0, 2 * W * H + 20);
        tests++;
        if (!r_abort) begin
            fails++;
            $display("FAIL abort_point: got no ch2 read, expected read at %0d", 2 * W * H + 20);
        end
        reset = 1'b0;
        #1 check_reset_vals("midframe");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_frame(-1);
        run_frame(1'b0, -1);
        check_frame("after_reset", BUSY_NOM, 1'b0);
    endtask

    task automatic test_start_held();
        push_frame(-1);
        run_frame(1'b1, -1);
        check_frame("held", BUSY_NOM, 1'b0);
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL held_idle: got busy=%0b, expected 0", busy);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL held_restart: got busy=%0b, expected 1", busy);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_drop();
        test_excess();
        test_reset_midframe();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end
endmodule
